// File: rtl/soda_pkg.sv
// Shared types and constants for the soda dispenser money path.
// It holds the controller state encoding, the default widths and the coin values.
package soda_pkg;

   typedef enum logic [1:0] {
      COLLECT  = 2'd0,
      DISPENSE = 2'd1,
      CHANGE   = 2'd2
   } state_e;

   localparam int W_DEF    = 8;
   localparam int UNIT_DEF = 5;

   // These coin values are used by the benches to build stimulus.
   localparam int COIN_NICKEL  = 5;
   localparam int COIN_DIME    = 10;
   localparam int COIN_QUARTER = 25;

endpackage

// File: rtl/soda_total_acc.sv
// Running-total register for the soda controller.
// It has add, subtract and clear operations, plus overflow and compare flags.
module soda_total_acc
   import soda_pkg::*;
#(
   parameter int W = W_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         add_i,
   input  logic [W-1:0] add_amt_i,
   input  logic         sub_i,
   input  logic [W-1:0] sub_amt_i,
   input  logic         clr_i,
   input  logic [W-1:0] cmp_amt_i,
   output logic [W-1:0] total_o,
   output logic         fits_o,
   output logic         ge_o
);

   logic [W-1:0] total_q, total_d;
   logic [W:0]   sum;

   // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      sum     = {1'b0, total_q} + {1'b0, add_amt_i};
      total_d = total_q;
      if (clr_i) begin
         total_d = '0;
      end else if (sub_i) begin
         total_d = total_q - sub_amt_i;
      end else if (add_i) begin
         total_d = sum[W-1:0];
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register samples the values from before the edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         total_q <= '0;
      end else begin
         total_q <= total_d;
      end
   end

   assign total_o = total_q;
   assign fits_o  = ~sum[W];
   assign ge_o    = (total_q >= cmp_amt_i);

endmodule

// File: rtl/soda_change_ctrl.sv
// Money-path controller: it collects coins, runs the dispense handshake and refunds change one UNIT at a time.
// Every output is registered. The total lives in soda_total_acc, and this FSM only chooses its operation.
module soda_change_ctrl
   import soda_pkg::*;
#(
   parameter int W    = W_DEF,
   parameter int UNIT = UNIT_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         coin_valid,
   input  logic [W-1:0] coin_amt,
   input  logic [W-1:0] price,
   input  logic         cancel,
   input  logic         disp_ack,
   input  logic         ej_ack,
   output logic         disp_req,
   output logic         ej_req,
   output logic         coin_reject,
   output logic         short_change,
   output logic         busy,
   output logic [W-1:0] total
);

   localparam logic [W-1:0] UNIT_W = W'(UNIT);

   state_e       state_q;
   logic         disp_req_q, ej_req_q, coin_reject_q, short_change_q, busy_q;
   logic         acc_add, acc_sub, acc_clr;
   logic [W-1:0] sub_amt, cmp_amt;
   logic [W-1:0] total_w;
   logic         fits, ge;
   logic         total_nz, disp_cond;

   soda_total_acc #(.W(W)) u_acc (
      .clk       (clk),
      .rst       (rst),
      .add_i     (acc_add),
      .add_amt_i (coin_amt),
      .sub_i     (acc_sub),
      .sub_amt_i (sub_amt),
      .clr_i     (acc_clr),
      .cmp_amt_i (cmp_amt),
      .total_o   (total_w),
      .fits_o    (fits),
      .ge_o      (ge)
   );

   assign total_nz  = (total_w != '0);
   assign disp_cond = (price != '0) && ge;

   // The comparator checks against price while collecting, and against UNIT while paying change.
   always_comb begin
      acc_add = 1'b0;
      acc_sub = 1'b0;
      acc_clr = 1'b0;
      sub_amt = price;
      cmp_amt = price;
      case (state_q)
         COLLECT:  acc_add = coin_valid & fits;
         DISPENSE: acc_sub = disp_req_q & disp_ack;
         CHANGE: begin
            cmp_amt = UNIT_W;
            sub_amt = UNIT_W;
            acc_sub = ej_req_q & ej_ack;
            acc_clr = ~ej_req_q & ~ge;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= COLLECT;
         disp_req_q     <= 1'b0;
         ej_req_q       <= 1'b0;
         coin_reject_q  <= 1'b0;
         short_change_q <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         coin_reject_q  <= coin_valid & ((state_q != COLLECT) | ~fits);
         short_change_q <= 1'b0;
         case (state_q)
            COLLECT: begin
               if (disp_cond) begin
                  state_q    <= DISPENSE;
                  disp_req_q <= 1'b1;
                  busy_q     <= 1'b1;
               end else if (cancel && !coin_valid && total_nz) begin
                  // A coin that arrives together with cancel is credited first; the refund starts on the next cycle.
                  state_q <= CHANGE;
                  busy_q  <= 1'b1;
               end
            end
            DISPENSE: begin
               if (disp_req_q && disp_ack) begin
                  state_q    <= CHANGE;
                  disp_req_q <= 1'b0;
               end
            end
            CHANGE: begin
               if (ej_req_q) begin
                  if (ej_ack) begin
                     ej_req_q <= 1'b0;
                  end
               end else if (ge) begin
                  ej_req_q <= 1'b1;
               end else begin
                  short_change_q <= total_nz;
                  state_q        <= COLLECT;
                  busy_q         <= 1'b0;
               end
            end
            default: begin
               state_q    <= COLLECT;
               disp_req_q <= 1'b0;
               ej_req_q   <= 1'b0;
               busy_q     <= 1'b0;
            end
         endcase
      end
   end

   assign disp_req     = disp_req_q;
   assign ej_req       = ej_req_q;
   assign coin_reject  = coin_reject_q;
   assign short_change = short_change_q;
   assign busy         = busy_q;
   assign total        = total_w;

endmodule

// File: tb/tb_soda_change_ctrl.sv
// Directed bench for soda_change_ctrl (W=8, UNIT=5).
// Expected values are computed by hand and written out step by step.
module tb_soda_change_ctrl;
   import soda_pkg::*;

   localparam int W = 8;

   logic         clk;
   logic         rst;
   logic         coin_valid;
   logic [W-1:0] coin_amt;
   logic [W-1:0] price;
   logic         cancel;
   logic         disp_ack;
   logic         ej_ack;
   logic         disp_req;
   logic         ej_req;
   logic         coin_reject;
   logic         short_change;
   logic         busy;
   logic [W-1:0] total;

   int checks   = 0;
   int failures = 0;

   soda_change_ctrl #(.W(W), .UNIT(5)) dut (
      .clk          (clk),
      .rst          (rst),
      .coin_valid   (coin_valid),
      .coin_amt     (coin_amt),
      .price        (price),
      .cancel       (cancel),
      .disp_ack     (disp_ack),
      .ej_ack       (ej_ack),
      .disp_req     (disp_req),
      .ej_req       (ej_req),
      .coin_reject  (coin_reject),
      .short_change (short_change),
      .busy         (busy),
      .total        (total)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic coin(input int amt);
      coin_valid = 1'b1;
      coin_amt   = W'(amt);
      step();
      coin_valid = 1'b0;
   endtask

   initial begin
      rst        = 1'b0;
      coin_valid = 1'b0;
      coin_amt   = '0;
      price      = 8'd75;
      cancel     = 1'b0;
      disp_ack   = 1'b0;
      ej_ack     = 1'b0;
      repeat (2) step();
      check("rst_total", total, 0);
      check("rst_disp_req", disp_req, 0);
      check("rst_ej_req", ej_req, 0);
      check("rst_coin_reject", coin_reject, 0);
      check("rst_short_change", short_change, 0);
      check("rst_busy", busy, 0);
      rst = 1'b1;
      step();

      // Exact payment: the price is 75.
      coin(COIN_QUARTER); coin(COIN_QUARTER); coin(COIN_QUARTER);
      check("t1_total", total, 75);
      check("t1_no_req_on_credit_edge", disp_req, 0);
      step();
      check("t1_disp_req", disp_req, 1);
      check("t1_busy", busy, 1);
      disp_ack = 1'b1; step(); disp_ack = 1'b0;
      check("t1_total_after_ack", total, 0);
      check("t1_disp_req_drop", disp_req, 0);
      step();
      check("t1_busy_done", busy, 0);
      check("t1_no_ej", ej_req, 0);
      check("t1_no_short", short_change, 0);

      // Price 60, 75 inserted: 15 change, paid as three ejects.
      price = 8'd60;
      coin(COIN_QUARTER); coin(COIN_QUARTER); coin(COIN_QUARTER);
      step();
      check("t2_disp_req", disp_req, 1);
      disp_ack = 1'b1; step(); disp_ack = 1'b0;
      check("t2_total_after_ack", total, 15);
      for (int i = 0; i < 3; i++) begin
         step();
         check("t2_ej_req", ej_req, 1);
         check("t2_exclusive", disp_req, 0);
         ej_ack = 1'b1; step(); ej_ack = 1'b0;
         check("t2_total_step", total, 32'(15 - 5 * (i + 1)));
         check("t2_ej_drop", ej_req, 0);
      end
      step();
      check("t2_busy_done", busy, 0);
      check("t2_no_extra_ej", ej_req, 0);
      check("t2_no_short", short_change, 0);

      // Price 50: dispense, then a refund with cancel held alongside the second coin.
      price = 8'd50;
      coin(COIN_QUARTER); coin(COIN_QUARTER);
      step();
      check("t3_disp_req", disp_req, 1);
      disp_ack = 1'b1; step(); disp_ack = 1'b0;
      check("t3_total_after_ack", total, 0);
      step();
      check("t3_back_collect", busy, 0);
      coin(COIN_DIME);
      cancel = 1'b1;
      coin(COIN_DIME);
      check("t3_credit_before_cancel", total, 20);
      check("t3_not_busy_on_credit", busy, 0);
      step();
      cancel = 1'b0;
      check("t3_refund_busy", busy, 1);
      check("t3_refund_ej_low", ej_req, 0);
      for (int i = 0; i < 4; i++) begin
         step();
         check("t3_ej_req", ej_req, 1);
         ej_ack = 1'b1; step(); ej_ack = 1'b0;
         check("t3_total_step", total, 32'(20 - 5 * (i + 1)));
      end
      step();
      check("t3_refund_done", busy, 0);
      check("t3_no_short", short_change, 0);
      cancel = 1'b1; step(); cancel = 1'b0;
      check("t3_cancel_zero_busy", busy, 0);
      check("t3_cancel_zero_ej", ej_req, 0);
      step();
      check("t3_cancel_zero_idle", busy, 0);

      // Price 7, 10 inserted: the residue of 3 is forfeited.
      price = 8'd7;
      coin(COIN_NICKEL); coin(COIN_NICKEL);
      check("t4_total", total, 10);
      step();
      check("t4_disp_req", disp_req, 1);
      disp_ack = 1'b1; step(); disp_ack = 1'b0;
      check("t4_total_after_ack", total, 3);
      step();
      check("t4_short_change", short_change, 1);
      check("t4_total_cleared", total, 0);
      check("t4_no_ej", ej_req, 0);
      check("t4_idle", busy, 0);
      step();
      check("t4_short_pulse", short_change, 0);

      // A coin inserted during dispense is rejected.
      price = 8'd25;
      coin(COIN_QUARTER);
      step();
      check("t5_disp_req", disp_req, 1);
      coin(COIN_DIME);
      check("t5_reject_busy", coin_reject, 1);
      check("t5_total_kept", total, 25);
      step();
      check("t5_reject_pulse", coin_reject, 0);
      disp_ack = 1'b1; step(); disp_ack = 1'b0;
      step();
      check("t5_idle", busy, 0);

      // Out of service: coins accumulate to 250, then an overflowing coin is rejected.
      price = 8'd0;
      for (int i = 0; i < 10; i++) coin(COIN_QUARTER);
      check("t5_total_250", total, 250);
      check("t5_no_dispense", disp_req, 0);
      coin(COIN_QUARTER);
      check("t5_overflow_reject", coin_reject, 1);
      check("t5_overflow_total", total, 250);
      step();
      check("t5_overflow_pulse", coin_reject, 0);
      check("t5_total_still_250", total, 250);

      // Reset asserted mid-refund while ej_req is high.
      cancel = 1'b1; step(); cancel = 1'b0;
      check("t6_refund_busy", busy, 1);
      step();
      check("t6_ej_req", ej_req, 1);
      rst = 1'b0;
      #1;
      check("t6_rst_total", total, 0);
      check("t6_rst_ej_req", ej_req, 0);
      check("t6_rst_busy", busy, 0);
      check("t6_rst_disp_req", disp_req, 0);
      check("t6_rst_coin_reject", coin_reject, 0);
      check("t6_rst_short", short_change, 0);
      #2;
      rst    = 1'b1;
      ej_ack = 1'b1;
      step();
      ej_ack = 1'b0;
      check("t6_stray_ack_ej", ej_req, 0);
      check("t6_stray_ack_total", total, 0);
      check("t6_stray_ack_busy", busy, 0);
      coin(COIN_DIME);
      check("t6_fresh_credit", total, 10);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: observed=running expected=finished");
      $fatal(1, "simulation time limit");
   end

endmodule
